// File: rtl/fifo_rd_streamer.sv
// FIFO read-side streamer: 2-entry skid buffer, 2-cycle read-to-valid latency, 1 beat/cycle; holds m_valid/m_data under backpressure.
// Optional STREAM_LAST_EN adds m_last from a PKT_LEN-beat packet counter.
module fifo_rd_streamer #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 16
`ifdef STREAM_LAST_EN
    ,
    parameter int PKT_LEN   = 4
`endif
) (
    input  logic                 rclk,
    input  logic                 rrst_n,
    input  logic                 flush,
    input  logic                 fifo_empty,
    input  logic [WIDTH-1:0]     fifo_rdata,
    output logic                 fifo_read_en,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [WIDTH-1:0]     m_data,
    output logic [CNT_WIDTH-1:0] beat_count
`ifdef STREAM_LAST_EN
    ,
    output logic                 m_last
`endif
);

    logic [WIDTH-1:0]     buf_q [2];
    logic [WIDTH-1:0]     buf_d [2];
    logic [1:0]           count_q, count_d;
    logic                 inflight_q, inflight_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] beat_count_q, beat_count_d;
    logic                 pop;
    logic                 capture;
    logic [1:0]           occupancy;

    assign m_valid    = (count_q != 2'd0);
    assign m_data     = buf_q[rd_ptr_q];
    assign beat_count = beat_count_q;

    always_comb begin
        pop       = m_valid && m_ready;
        // Data for a read issued just before a flush belongs to the discarded stream.
        capture   = inflight_q && !flush;
        occupancy = count_q + {1'b0, inflight_q};
        fifo_read_en = rrst_n && !fifo_empty && !flush && ((occupancy < 2'd2) || pop);

        buf_d = buf_q;
        if (capture) begin
            buf_d[wr_ptr_q] = fifo_rdata;
        end

        inflight_d = fifo_read_en;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            count_d  = count_q + {1'b0, capture} - {1'b0, pop};
            wr_ptr_d = wr_ptr_q ^ capture;
            rd_ptr_d = rd_ptr_q ^ pop;
        end

        beat_count_d = beat_count_q;
        if (pop && (beat_count_q != {CNT_WIDTH{1'b1}})) begin
            beat_count_d = beat_count_q + 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            buf_q        <= '{default: '0};
            count_q      <= 2'd0;
            inflight_q   <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            beat_count_q <= '0;
        end else begin
            buf_q        <= buf_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            beat_count_q <= beat_count_d;
        end
    end

`ifdef STREAM_LAST_EN
    localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [PW-1:0] PKT_LAST = PW'(PKT_LEN - 1);

    logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (flush) begin
            pkt_cnt_d = '0;
        end else if (pop) begin
            pkt_cnt_d = (pkt_cnt_q == PKT_LAST) ? '0 : pkt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    // Gated by m_valid so an idle stream never shows a stray last flag.
    assign m_last = m_valid && (pkt_cnt_q == PKT_LAST);
`endif

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: queue-based reference model of the buffer, randomized traffic plus directed scenarios.
module tb_fifo_rd_streamer;
    localparam int W     = 8;
    localparam int CNT_W = 5;
    localparam int PKT   = 4;
    localparam int MAXB  = (1 << CNT_W) - 1;

    logic             rclk = 1'b0;
    logic             rrst_n = 1'b0;
    logic             flush = 1'b0;
    logic             fifo_empty = 1'b1;
    logic [W-1:0]     fifo_rdata = '0;
    logic             fifo_read_en;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [W-1:0]     m_data;
    logic [CNT_W-1:0] beat_count;
`ifdef STREAM_LAST_EN
    logic             m_last;
`endif

    fifo_rd_streamer #(
        .WIDTH(W),
        .CNT_WIDTH(CNT_W)
`ifdef STREAM_LAST_EN
        ,
        .PKT_LEN(PKT)
`endif
    ) dut (
        .rclk(rclk),
        .rrst_n(rrst_n),
        .flush(flush),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .fifo_read_en(fifo_read_en),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data(m_data),
        .beat_count(beat_count)
`ifdef STREAM_LAST_EN
        ,
        .m_last(m_last)
`endif
    );

    always #5 rclk = ~rclk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Source FIFO contents and reference model of the streamer.
    logic [W-1:0] fq[$];
    logic [W-1:0] bq[$];
    bit           infl = 1'b0;
    logic [W-1:0] infl_word = '0;
    bit           pend_rd = 1'b0;
    logic [W-1:0] pend_word = '0;
    int           beats_m = 0;
    int           pkt_m = 0;
    bit           rel_pend = 1'b0;

    bit           obs_rd, obs_valid, obs_pop, obs_last;
    logic [W-1:0] obs_data;
    int           obs_bc;

    task automatic step(input bit rdy, input bit fl);
        bit e_valid, e_rd, e_last, pop;
        @(negedge rclk);
        cyc++;
        if (rel_pend) begin
            rrst_n = 1'b1;
            rel_pend = 1'b0;
        end
        fifo_rdata = pend_rd ? pend_word : W'($urandom);
        m_ready = rdy;
        flush = fl;
        fifo_empty = (fq.size() == 0);
        #1;
        e_valid = (bq.size() != 0);
        e_rd = !fifo_empty && !fl && (((bq.size() + int'(infl)) < 2) || (e_valid && rdy));
        e_last = e_valid && (pkt_m == PKT - 1);
        obs_rd = (fifo_read_en === 1'b1);
        obs_valid = (m_valid === 1'b1);
        obs_data = m_data;
        obs_pop = obs_valid && rdy;
        obs_bc = int'(beat_count);
`ifdef STREAM_LAST_EN
        obs_last = (m_last === 1'b1);
`else
        obs_last = 1'b0;
`endif
        total++;
        if (fifo_read_en !== e_rd) begin
            bad++;
            $display("FAIL read_en cyc=%0d got=%b exp=%b", cyc, fifo_read_en, e_rd);
        end
        total++;
        if (fifo_read_en === 1'b1 && fifo_empty) begin
            bad++;
            $display("FAIL read_while_empty cyc=%0d got=1 exp=0", cyc);
        end
        total++;
        if (m_valid !== e_valid) begin
            bad++;
            $display("FAIL m_valid cyc=%0d got=%b exp=%b", cyc, m_valid, e_valid);
        end
        if (e_valid) begin
            total++;
            if (m_data !== bq[0]) begin
                bad++;
                $display("FAIL m_data cyc=%0d got=%h exp=%h", cyc, m_data, bq[0]);
            end
        end
        total++;
        if (beat_count !== CNT_W'(beats_m)) begin
            bad++;
            $display("FAIL beat_count cyc=%0d got=%0d exp=%0d", cyc, beat_count, beats_m);
        end
`ifdef STREAM_LAST_EN
        total++;
        if (m_last !== e_last) begin
            bad++;
            $display("FAIL m_last cyc=%0d got=%b exp=%b", cyc, m_last, e_last);
        end
`else
        if (e_last) pkt_m = pkt_m;
`endif
        pop = e_valid && rdy;
        if (pop) begin
            void'(bq.pop_front());
            if (beats_m < MAXB) beats_m++;
            pkt_m = (pkt_m == PKT - 1) ? 0 : pkt_m + 1;
        end
        if (fl) begin
            bq.delete();
            pkt_m = 0;
        end else if (infl) begin
            bq.push_back(infl_word);
        end
        // The environment FIFO answers the DUT's actual strobe one cycle later.
        pend_rd = obs_rd;
        if (pend_rd) pend_word = (fq.size() != 0) ? fq.pop_front() : W'(8'hEE);
        infl = e_rd;
        infl_word = pend_word;
    endtask

    task automatic apply_reset();
        @(negedge rclk);
        rrst_n = 1'b0;
        flush = 1'b0;
        m_ready = 1'b1;
        fifo_empty = (fq.size() == 0);
        #1;
        total++;
        if (fifo_read_en !== 1'b0) begin bad++; $display("FAIL rst_read_en got=%b exp=0", fifo_read_en); end
        total++;
        if (m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%b exp=0", m_valid); end
        total++;
        if (m_data !== '0) begin bad++; $display("FAIL rst_m_data got=%h exp=00", m_data); end
        total++;
        if (beat_count !== '0) begin bad++; $display("FAIL rst_beat_count got=%0d exp=0", beat_count); end
`ifdef STREAM_LAST_EN
        total++;
        if (m_last !== 1'b0) begin bad++; $display("FAIL rst_m_last got=%b exp=0", m_last); end
`endif
        bq.delete();
        infl = 1'b0;
        pend_rd = 1'b0;
        beats_m = 0;
        pkt_m = 0;
        rel_pend = 1'b1;
    endtask

    task automatic test_reset();
        fq.push_back(8'h11);
        apply_reset();
        fq.delete();
        fifo_empty = 1'b1;
    endtask

    task automatic test_basic_latency();
        int t_rd = -1;
        int t_v = -1;
        fq.push_back(8'hA1);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0);
            if (obs_rd && t_rd < 0) t_rd = i;
            if (obs_valid && t_v < 0) begin
                t_v = i;
                total++;
                if (obs_data !== 8'hA1) begin bad++; $display("FAIL basic_data got=%h exp=a1", obs_data); end
            end
        end
        total++;
        if (t_rd < 0 || t_v - t_rd != 2) begin bad++; $display("FAIL basic_latency got=%0d exp=2", t_v - t_rd); end
        total++;
        if (obs_bc != 1) begin bad++; $display("FAIL basic_beat_count got=%0d exp=1", obs_bc); end
    endtask

    task automatic test_streaming();
        int first = -1;
        int last = -1;
        int pops = 0;
        for (int k = 0; k < 16; k++) fq.push_back(W'(k));
        for (int i = 0; i < 22; i++) begin
            step(1'b1, 1'b0);
            if (obs_pop) begin
                total++;
                if (obs_data !== W'(pops)) begin bad++; $display("FAIL stream_order got=%h exp=%h", obs_data, W'(pops)); end
                if (first < 0) first = i;
                last = i;
                pops++;
            end
        end
        total++;
        if (pops != 16) begin bad++; $display("FAIL stream_beats got=%0d exp=16", pops); end
        total++;
        if (last - first != 15) begin bad++; $display("FAIL stream_gapless got=%0d exp=15", last - first); end
        total++;
        if (obs_bc != 17) begin bad++; $display("FAIL stream_beat_count got=%0d exp=17", obs_bc); end
    endtask

    task automatic test_backpressure();
        int pops = 0;
        bit held = 1'b0;
        logic [W-1:0] held_data = '0;
        for (int k = 0; k < 10; k++) fq.push_back(W'(8'h40 + k));
        for (int i = 0; i < 25; i++) begin
            bit rdy;
            rdy = !(i >= 5 && i < 10);
            step(rdy, 1'b0);
            if (!rdy && obs_valid) begin
                if (held) begin
                    total++;
                    if (obs_data !== held_data) begin bad++; $display("FAIL bp_stable got=%h exp=%h", obs_data, held_data); end
                end
                held = 1'b1;
                held_data = obs_data;
            end
            if (i == 9) begin
                total++;
                if (obs_rd) begin bad++; $display("FAIL bp_no_read_when_full got=1 exp=0"); end
            end
            if (obs_pop) begin
                total++;
                if (obs_data !== W'(8'h40 + pops)) begin bad++; $display("FAIL bp_order got=%h exp=%h", obs_data, W'(8'h40 + pops)); end
                pops++;
            end
        end
        total++;
        if (pops != 10) begin bad++; $display("FAIL bp_beats got=%0d exp=10", pops); end
    endtask

    task automatic test_flush_inflight();
        bit got = 1'b0;
        int pops = 0;
        for (int k = 0; k < 4; k++) fq.push_back(W'(8'h30 + k));
        step(1'b0, 1'b0);
        total++;
        if (!obs_rd) begin bad++; $display("FAIL flush_pre_read got=0 exp=1"); end
        step(1'b0, 1'b1);
        total++;
        if (obs_rd) begin bad++; $display("FAIL flush_read_en got=1 exp=0"); end
        step(1'b0, 1'b0);
        total++;
        if (obs_valid) begin bad++; $display("FAIL flush_valid got=1 exp=0"); end
        total++;
        if (obs_bc != 27) begin bad++; $display("FAIL flush_beat_count got=%0d exp=27", obs_bc); end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            if (obs_pop) begin
                pops++;
                if (!got) begin
                    got = 1'b1;
                    total++;
                    if (obs_data !== 8'h31) begin bad++; $display("FAIL flush_next_word got=%h exp=31", obs_data); end
                end
            end
        end
        total++;
        if (pops != 3) begin bad++; $display("FAIL flush_beats got=%0d exp=3", pops); end
    endtask

    task automatic test_reset_mid();
        int t_rd = -1;
        int t_v = -1;
        for (int k = 0; k < 6; k++) fq.push_back(W'(8'h50 + k));
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        total++;
        if (!obs_valid) begin bad++; $display("FAIL midrst_buffered got=0 exp=1"); end
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0);
            if (obs_rd && t_rd < 0) t_rd = i;
            if (obs_valid && t_v < 0) begin
                t_v = i;
                total++;
                if (obs_data !== 8'h52) begin bad++; $display("FAIL midrst_first got=%h exp=52", obs_data); end
            end
        end
        total++;
        if (t_rd < 0 || t_v - t_rd != 2) begin bad++; $display("FAIL midrst_latency got=%0d exp=2", t_v - t_rd); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0 && fq.size() < 8) fq.push_back(W'($urandom));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
        end
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0);
        total++;
        if (obs_bc != MAXB) begin bad++; $display("FAIL saturate got=%0d exp=%0d", obs_bc, MAXB); end
    endtask

`ifdef STREAM_LAST_EN
    task automatic test_pkt_last();
        bit lasts[9];
        int pops = 0;
        int stall = 3;
        apply_reset();
        for (int k = 0; k < 9; k++) fq.push_back(W'(8'h70 + k));
        for (int i = 0; i < 24; i++) begin
            bit rdy;
            rdy = !(pops == 3 && stall > 0 && bq.size() != 0);
            step(rdy, 1'b0);
            if (obs_pop && pops < 9) begin
                lasts[pops] = obs_last;
                pops++;
            end else if (!rdy) begin
                stall--;
            end
        end
        for (int k = 0; k < 9; k++) begin
            total++;
            if (lasts[k] !== (k == 3 || k == 7)) begin bad++; $display("FAIL pkt_last beat=%0d got=%b exp=%b", k, lasts[k], (k == 3 || k == 7)); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_latency();
        test_streaming();
        test_backpressure();
        test_flush_inflight();
        test_reset_mid();
        test_random();
`ifdef STREAM_LAST_EN
        test_pkt_last();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
